// File: rtl/key_control_core.sv
// rtl/key_control_core.sv - debounced four-key waveform selector
//
// Purpose:
//   Four active-low pushbuttons are synchronized, debounced independently and
//   turned into single press events. The lowest-indexed key with a press
//   event selects the waveform. The selection is held until another press.
//
// Ports:
//   sys_clk     in   system clock, all state updates on the rising edge
//   sys_rst     in   asynchronous active-high reset
//   key[3:0]    in   raw pushbuttons, 0 = pressed, asynchronous, may bounce
//   wave_select out  registered one-hot selection
//                    0001 sine, 0010 square, 0100 triangle, 1000 sawtooth
//                    0000 only after reset, before the first press
module key_control_core #(
   parameter int CNT_MAX = 999_999
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic [3:0] key,
   output logic [3:0] wave_select
);

   localparam int CW = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] CNT_TOP  = CW'(CNT_MAX);
   localparam logic [CW-1:0] CNT_FIRE = CW'(CNT_MAX - 1);

   logic [3:0]          sync_a;
   logic [3:0]          sync_b;
   logic [3:0][CW-1:0]  cnt;
   logic [3:0]          press;
   logic [3:0]          next_select;

   // Two-flop synchronizer; reset to the released level so nothing looks
   // pressed while the keys are still being sampled after reset.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         sync_a <= 4'hF;
         sync_b <= 4'hF;
      end else begin
         sync_a <= key;
         sync_b <= sync_a;
      end
   end

   // Per-key stability counter: cleared whenever the synchronized level is
   // high, saturates at CNT_TOP so a long hold never wraps back into an event.
   for (genvar g = 0; g < 4; g++) begin : g_debounce
      always_ff @(posedge sys_clk or posedge sys_rst) begin
         if (sys_rst) begin
            cnt[g] <= '0;
         end else if (sync_b[g]) begin
            cnt[g] <= '0;
         end else if (cnt[g] != CNT_TOP) begin
            cnt[g] <= cnt[g] + 1'b1;
         end
      end

      // Fires on exactly one edge per stable press: the edge on which the
      // counter steps from CNT_FIRE to CNT_TOP.
      always_comb begin
         press[g] = !sync_b[g] && (cnt[g] == CNT_FIRE);
      end
   end

   // Lowest index wins: scan from the top so lower keys overwrite higher.
   always_comb begin
      next_select = wave_select;
      for (int i = 3; i >= 0; i--) begin
         if (press[i]) begin
            next_select = 4'b0001 << i;
         end
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         wave_select <= 4'b0000;
      end else begin
         wave_select <= next_select;
      end
   end

endmodule

// File: tb/tb_key_control_core.sv
// tb/tb_key_control_core.sv - self-checking bench for key_control_core
module tb_key_control_core;

   localparam int CNT_MAX = 24;
   localparam int LATENCY = CNT_MAX + 2;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic [3:0] key = 4'hF;
   logic [3:0] wave_select;

   int tests_run = 0;
   int tests_failed = 0;

   key_control_core #(.CNT_MAX(CNT_MAX)) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .key         (key),
      .wave_select (wave_select)
   );

   always #5 sys_clk = ~sys_clk;

   // Reference model: a key produces one press event two edges after the
   // edge at which it has been sampled low for exactly CNT_MAX consecutive
   // edges (the two edges are the synchronizer delay).
   logic [3:0] exp_ws = 4'b0000;
   logic [3:0] m_pipe1 = 4'b0000;
   logic [3:0] m_pipe2 = 4'b0000;
   logic [3:0] m_ev;
   logic [3:0] m_hit;
   int         m_run [4];

   always @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         exp_ws  = 4'b0000;
         m_pipe1 = 4'b0000;
         m_pipe2 = 4'b0000;
         for (int i = 0; i < 4; i++) m_run[i] = 0;
      end else begin
         m_ev    = m_pipe2;
         m_pipe2 = m_pipe1;
         for (int i = 0; i < 4; i++) begin
            if (key[i] == 1'b0) m_run[i] = m_run[i] + 1;
            else                m_run[i] = 0;
            m_hit[i] = (m_run[i] == CNT_MAX);
         end
         m_pipe1 = m_hit;
         for (int i = 3; i >= 0; i--) begin
            if (m_ev[i]) exp_ws = 4'b0001 << i;
         end
      end
   end

   // Apply a key pattern and advance to the next falling edge.
   task automatic tick(input logic [3:0] k);
      key = k;
      @(negedge sys_clk);
   endtask

   task automatic test_reset;
      sys_rst = 1'b1;
      key = 4'hF;
      repeat (3) @(negedge sys_clk);
      tests_run++;
      if (wave_select !== 4'b0000) begin
         tests_failed++;
         $display("FAIL reset_state: wave_select=%b expected 0000", wave_select);
      end
      sys_rst = 1'b0;
      for (int c = 0; c < 500; c++) begin
         tick(4'hF);
         tests_run++;
         if (wave_select !== 4'b0000 || exp_ws !== 4'b0000) begin
            tests_failed++;
            $display("FAIL idle_after_reset cycle %0d: wave_select=%b expected 0000", c, wave_select);
         end
      end
   endtask

   task automatic test_key_cycle(input int idx);
      logic [3:0] pressed;
      logic [3:0] code;
      logic [3:0] start_ws;
      logic [3:0] prev;
      logic [3:0] k;
      int changes;
      int change_edge;
      int exp_changes;
      int exp_edge;
      pressed = 4'hF;
      pressed[idx] = 1'b0;
      code = 4'b0001 << idx;
      start_ws = exp_ws;
      prev = wave_select;
      changes = 0;
      change_edge = -1;
      // Random bouncing, forced high at least every 8 cycles and at the end.
      for (int c = 0; c < 50; c++) begin
         k = ($urandom_range(0, 1) == 1 && (c % 8) != 7 && c != 49) ? pressed : 4'hF;
         tick(k);
         tests_run++;
         if (wave_select !== exp_ws) begin
            tests_failed++;
            $display("FAIL key%0d_bounce_in cycle %0d: wave_select=%b expected %b", idx, c, wave_select, exp_ws);
         end
         if (wave_select !== prev) begin changes++; prev = wave_select; end
      end
      for (int c = 1; c <= 40; c++) begin
         tick(pressed);
         tests_run++;
         if (wave_select !== exp_ws) begin
            tests_failed++;
            $display("FAIL key%0d_stable edge %0d: wave_select=%b expected %b", idx, c, wave_select, exp_ws);
         end
         if (wave_select !== prev) begin changes++; change_edge = c; prev = wave_select; end
      end
      for (int c = 0; c < 20; c++) begin
         k = ($urandom_range(0, 1) == 1 && c < 10 && (c % 8) != 7) ? pressed : 4'hF;
         tick(k);
         tests_run++;
         if (wave_select !== exp_ws) begin
            tests_failed++;
            $display("FAIL key%0d_bounce_out cycle %0d: wave_select=%b expected %b", idx, c, wave_select, exp_ws);
         end
         if (wave_select !== prev) begin changes++; prev = wave_select; end
      end
      exp_changes = (start_ws == code) ? 0 : 1;
      exp_edge = (start_ws == code) ? -1 : LATENCY;
      tests_run++;
      if (changes != exp_changes || change_edge != exp_edge) begin
         tests_failed++;
         $display("FAIL key%0d_change_count: changes=%0d at edge %0d expected %0d at edge %0d",
                  idx, changes, change_edge, exp_changes, exp_edge);
      end
      tests_run++;
      if (wave_select !== code) begin
         tests_failed++;
         $display("FAIL key%0d_final: wave_select=%b expected %b", idx, wave_select, code);
      end
   endtask

   task automatic test_short_runs;
      logic [3:0] start_ws;
      start_ws = exp_ws;
      for (int c = 0; c < 46; c++) begin
         tick((c == 20 || c >= 41) ? 4'hF : 4'b1011);
         tests_run++;
         if (wave_select !== start_ws || exp_ws !== start_ws) begin
            tests_failed++;
            $display("FAIL short_runs cycle %0d: wave_select=%b expected %b", c, wave_select, start_ws);
         end
      end
   endtask

   task automatic test_simultaneous;
      for (int c = 0; c < 45; c++) begin
         tick((c < 40) ? 4'b0101 : 4'hF);
         tests_run++;
         if (wave_select !== exp_ws) begin
            tests_failed++;
            $display("FAIL simultaneous cycle %0d: wave_select=%b expected %b", c, wave_select, exp_ws);
         end
      end
      tests_run++;
      if (wave_select !== 4'b0010) begin
         tests_failed++;
         $display("FAIL simultaneous_final: wave_select=%b expected 0010", wave_select);
      end
   endtask

   task automatic test_reset_mid_count;
      int change_edge;
      logic [3:0] prev;
      for (int c = 0; c < 15; c++) begin
         tick(4'hE);
         tests_run++;
         if (wave_select !== exp_ws) begin
            tests_failed++;
            $display("FAIL pre_reset cycle %0d: wave_select=%b expected %b", c, wave_select, exp_ws);
         end
      end
      sys_rst = 1'b1;
      #1;
      tests_run++;
      if (wave_select !== 4'b0000) begin
         tests_failed++;
         $display("FAIL async_reset: wave_select=%b expected 0000", wave_select);
      end
      @(negedge sys_clk);
      tests_run++;
      if (wave_select !== 4'b0000) begin
         tests_failed++;
         $display("FAIL reset_held: wave_select=%b expected 0000", wave_select);
      end
      sys_rst = 1'b0;
      prev = wave_select;
      change_edge = -1;
      for (int c = 1; c <= 40; c++) begin
         tick(4'hE);
         tests_run++;
         if (wave_select !== exp_ws) begin
            tests_failed++;
            $display("FAIL post_reset edge %0d: wave_select=%b expected %b", c, wave_select, exp_ws);
         end
         if (wave_select !== prev && change_edge < 0) change_edge = c;
         prev = wave_select;
      end
      tests_run++;
      if (change_edge != LATENCY || wave_select !== 4'b0001) begin
         tests_failed++;
         $display("FAIL reset_latency: change at edge %0d to %b expected edge %0d to 0001",
                  change_edge, wave_select, LATENCY);
      end
      repeat (5) tick(4'hF);
   endtask

   task automatic test_random_mix;
      int hold [4];
      logic [3:0] k;
      k = 4'hF;
      for (int i = 0; i < 4; i++) hold[i] = 0;
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < 4; i++) begin
            if (hold[i] == 0) begin
               k[i] = ~k[i];
               hold[i] = k[i] ? $urandom_range(1, 30) : $urandom_range(1, 40);
            end
            hold[i] = hold[i] - 1;
         end
         tick(k);
         tests_run++;
         if (wave_select !== exp_ws) begin
            tests_failed++;
            $display("FAIL random_mix cycle %0d: key=%b wave_select=%b expected %b", c, k, wave_select, exp_ws);
         end
         tests_run++;
         if (!$onehot0(wave_select)) begin
            tests_failed++;
            $display("FAIL random_onehot cycle %0d: wave_select=%b expected one-hot or zero", c, wave_select);
         end
      end
      repeat (5) tick(4'hF);
   endtask

   initial begin
      test_reset();
      test_key_cycle(0);
      test_key_cycle(1);
      test_key_cycle(2);
      test_key_cycle(3);
      test_key_cycle(0);
      test_key_cycle(0);
      test_short_runs();
      test_simultaneous();
      test_reset_mid_count();
      test_random_mix();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/key_control_core.md
KEY_CONTROL_CORE -- requirements
Module: key_control

Interface
REQ-001 Parameter CNT_MAX, default 999_999, debounce stability length in clock cycles (20 ms at 50 MHz). Benches use 24.
REQ-002 Port sys_clk, input, 1 bit: system clock, 50 MHz nominal, all logic on the rising edge.
REQ-003 Port sys_rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port key, input, 4 bits: raw mechanical pushbuttons, active-low (0 = pressed), asynchronous to sys_clk, may bounce.
REQ-005 Port wave_select, output, 4 bits, registered: one-hot waveform selection. 0001 = sine, 0010 = square, 0100 = triangle, 1000 = sawtooth.

Function
REQ-006 Each key bit SHALL pass through its own 2-flop synchronizer; the second flop is the synchronized level s[i].
- Synchronizer flops reset to 1 (released).
REQ-007 Each key SHALL have an independent debounce counter cnt[i], wide enough to hold CNT_MAX.
REQ-008 Counter rules, per edge:
- s[i]==1: cnt[i] <= 0.
- s[i]==0 and cnt[i]==CNT_MAX: hold (saturate).
- otherwise: cnt[i] <= cnt[i]+1.
REQ-009 Press event p[i] SHALL be combinational and true exactly when s[i]==0 and cnt[i]==CNT_MAX-1.
- Result: exactly one event per stable press, however long the key is held.
- No event for any low run shorter than CNT_MAX cycles of s[i]==0.
REQ-010 On an edge where any p[i] is true, wave_select SHALL load the one-hot code of the lowest-indexed i with p[i] true.
- key[0] -> 0001, key[1] -> 0010, key[2] -> 0100, key[3] -> 1000.
- Simultaneous events: lowest index wins; the others are discarded.
REQ-011 With no press event, wave_select SHALL hold its value; key release SHALL NOT change wave_select.
REQ-012 Pressing the key that is already selected SHALL leave wave_select unchanged.
REQ-013 Latency: with key[i] low and bounce-free from just before edge 1, wave_select SHALL update on edge CNT_MAX+2.
REQ-014 Any 1 on s[i] (bounce) SHALL restart that key's count from 0; the other keys' counters are unaffected.
REQ-015 wave_select SHALL always be 0000 or exactly one-hot.

Reset
REQ-016 While sys_rst=1, independent of the clock:
- wave_select = 0000.
- all cnt = 0.
- all synchronizer flops = 1.
REQ-017 Reset asserted mid-count SHALL discard the partial count.
- After release, a key held low needs a full CNT_MAX+2 edges before it produces an event.
REQ-018 After reset release with all keys high, wave_select SHALL remain 0000 indefinitely.

Verification (CNT_MAX=24)
REQ-019 Reset, keys 1111 -> wave_select 0000 for 500 cycles.
REQ-020 key[0] toggles randomly for 50 cycles, then stays low for 40 cycles, then bounces again and releases -> exactly one change to 0001, on edge 26 of the stable-low run; no other change.
REQ-021 Repeat REQ-020 on key[1], key[2], key[3] in turn -> 0010, 0100, 1000; then a key[0] cycle returns to 0001.
REQ-022 key[2] low for 20 cycles, high for 1 cycle, low for 20 cycles -> no change.
REQ-023 key[1] and key[3] fall on the same edge, held 40 cycles -> wave_select = 0010.
REQ-024 key[0] held low, sys_rst pulsed at cycle 15 -> wave_select 0000; becomes 0001 exactly 26 edges after release.
